// File: rtl/wb_led_blinker_pkg.sv
// wb_led_blinker_pkg: register map, CTRL/STAT bit positions and channel stride for the LED blinker
package wb_led_blinker_pkg;
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STAT   = 2'd3
  } reg_e;
  localparam int CTRL_EN = 0;
  localparam int CTRL_BLINK = 1;
  localparam int CTRL_LVL = 2;
  localparam int CTRL_IRQEN = 3;
  localparam int STAT_LED = 0;
  localparam int STAT_PEND = 1;
  localparam logic [31:0] CH_STRIDE = 32'h10;
endpackage

// File: rtl/led_blink_chan.sv
// led_blink_chan: one channel's CTRL/PERIOD registers, half-period counter, led flop and (with WB_LED_BLINKER_IRQ_EN) pending flag
module led_blink_chan
  import wb_led_blinker_pkg::*;
#(
  parameter int          CW = 27,
  parameter int unsigned DEFAULT_PERIOD = 100000000,
  parameter int          RST_BLINK = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_ctrl,
  input  logic          wr_period,
  input  logic          wr_stat,
  input  logic [31:0]   wdata,
  output logic [3:0]    ctrl,
  output logic [CW-1:0] period,
  output logic [CW-1:0] count,
  output logic          led,
  output logic          pending
);
  logic [3:0] ctrl_q, ctrl_d;
  logic [CW-1:0] period_q, period_d, count_q, count_d;
  logic led_q, led_d;
  logic blink_on, new_on, term, toggle;
  logic unused_ok;
  assign unused_ok = ^{wdata, wr_stat};
  // A config write restarts the count and beats a coinciding terminal count; leaving or entering blink resyncs led to LVL
  always_comb begin
    blink_on = ctrl_q[CTRL_EN] & ctrl_q[CTRL_BLINK];
    new_on = wdata[CTRL_EN] & wdata[CTRL_BLINK];
    term = (period_q != '0) && (count_q == period_q - 1'b1);
    toggle = blink_on & ~wr_ctrl & ~wr_period & term;
`ifdef WB_LED_BLINKER_IRQ_EN
    ctrl_d = wr_ctrl ? wdata[3:0] : ctrl_q;
`else
    ctrl_d = wr_ctrl ? {1'b0, wdata[2:0]} : ctrl_q;
`endif
    period_d = wr_period ? wdata[CW-1:0] : period_q;
    count_d = (wr_ctrl | wr_period | ~blink_on | term | (period_q == '0)) ? '0 : count_q + 1'b1;
    led_d = wr_ctrl ? ((blink_on & new_on) ? led_q : wdata[CTRL_LVL])
          : ~blink_on ? ctrl_q[CTRL_LVL] : led_q ^ toggle;
  end
  // Channel state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= (RST_BLINK != 0) ? 4'b0011 : 4'b0000;
      period_q <= CW'(DEFAULT_PERIOD);
      count_q <= '0;
      led_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      period_q <= period_d;
      count_q <= count_d;
      led_q <= led_d;
    end
  end
`ifdef WB_LED_BLINKER_IRQ_EN
  logic pending_q, pending_d;
  // Pending is W1C, but a toggle in the same cycle keeps it set
  always_comb pending_d = toggle | (pending_q & ~(wr_stat & wdata[STAT_PEND]));
  // Pending flag register
  always_ff @(posedge clk) begin
    if (reset) pending_q <= 1'b0;
    else pending_q <= pending_d;
  end
  assign pending = pending_q;
`else
  assign pending = 1'b0;
`endif
  assign ctrl = ctrl_q;
  assign period = period_q;
  assign count = count_q;
  assign led = led_q;
endmodule

// File: rtl/wb_led_blinker.sv
// wb_led_blinker: Wishbone slave with NCH blinking LED channels; define WB_LED_BLINKER_IRQ_EN for pending flags and irq
module wb_led_blinker
  import wb_led_blinker_pkg::*;
#(
  parameter int          NCH = 4,
  parameter int          CW = 27,
  parameter int unsigned DEFAULT_PERIOD = 100000000,
  parameter int          RST_BLINK = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wb_stb_i,
  input  logic           wb_cyc_i,
  output logic           wb_ack_o,
  input  logic           wb_we_i,
  input  logic [31:0]    wb_adr_i,
  input  logic [3:0]     wb_sel_i,
  input  logic [31:0]    wb_dat_i,
  output logic [31:0]    wb_dat_o,
  output logic [NCH-1:0] led
`ifdef WB_LED_BLINKER_IRQ_EN
  ,
  output logic           irq
`endif
);
  localparam int CH_LSB = $clog2(CH_STRIDE);
  logic ack_q, ack_d, wr;
  logic [31:0] dat_q, dat_d, rdata;
  logic [3:0] ch;
  reg_e rsel;
  logic [3:0] ctrl [NCH];
  logic [CW-1:0] period [NCH];
  logic [CW-1:0] count [NCH];
  logic [NCH-1:0] pending;
  logic unused_ok;
  assign unused_ok = ^{wb_sel_i, wb_adr_i};
  assign ch = wb_adr_i[CH_LSB +: 4];
  assign rsel = reg_e'(wb_adr_i[3:2]);
  // Ack rises the cycle after a request and never twice in a row; writes and read data commit on that edge
  always_comb begin
    ack_d = wb_stb_i & wb_cyc_i & ~ack_q;
    wr = ack_d & wb_we_i;
    dat_d = ack_d ? rdata : dat_q;
  end
  // Read mux; channels beyond NCH read as zero
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++)
      if (ch == 4'(i))
        rdata = (rsel == REG_CTRL) ? 32'(ctrl[i])
              : (rsel == REG_PERIOD) ? 32'(period[i])
              : (rsel == REG_COUNT) ? 32'(count[i])
              : 32'({pending[i], led[i]});
  end
  // Bus handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    led_blink_chan #(
      .CW(CW),
      .DEFAULT_PERIOD(DEFAULT_PERIOD),
      .RST_BLINK(RST_BLINK)
    ) u_chan (
      .clk(clk),
      .reset(reset),
      .wr_ctrl(wr && ch == 4'(g) && rsel == REG_CTRL),
      .wr_period(wr && ch == 4'(g) && rsel == REG_PERIOD),
      .wr_stat(wr && ch == 4'(g) && rsel == REG_STAT),
      .wdata(wb_dat_i),
      .ctrl(ctrl[g]),
      .period(period[g]),
      .count(count[g]),
      .led(led[g]),
      .pending(pending[g])
    );
  end
`ifdef WB_LED_BLINKER_IRQ_EN
  logic [NCH-1:0] irqen;
  logic irq_q, irq_d;
  for (genvar g = 0; g < NCH; g++) begin : g_ie
    assign irqen[g] = ctrl[g][CTRL_IRQEN];
  end
  // Interrupt is the registered OR of enabled pending flags
  always_comb irq_d = |(pending & irqen);
  // Interrupt register
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign irq = irq_q;
`endif
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o = dat_q;
endmodule
